fetch_queue: RTL and testbench

Instruction-fetch buffer between the PC generator and decode. It takes the fetch-stage program counter and issues in-order read requests to instruction memory. Each request reserves a queue entry holding its PC, and the returned instruction word fills that entry. Filled entries go to decode over a valid/ready handshake, and a branch-redirect flush discards all buffered and in-flight work.

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch, instruction-memory and decode signals of the fetch queue.
interface fetch_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          pc_valid;
  logic [31:0]   pc_in;
  logic          flush;
  logic          fetch_stall;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_instr;
  logic [CW-1:0] occupancy;
  modport master (
    output pc_valid, pc_in, flush, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
    input  fetch_stall, imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, occupancy
  );
  modport slave (
    input  pc_valid, pc_in, flush, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
    output fetch_stall, imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch buffer with flush and response discard.
// Define FETCH_QUEUE_BYPASS_EN for zero-cycle response-to-decode forwarding.
module fetch_queue #(parameter int DEPTH = 4) (
  input logic clk,
  input logic rst,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]  head_q, fill_q, tail_q;
  logic [CW-1:0]  occ_q, pend_q, discard_cnt_q, occ_d, pend_d, discard_cnt_d, owed;
  logic [DEPTH-1:0] filled_q;
  logic [31:0]    pc_q [DEPTH];
  logic [31:0]    instr_q [DEPTH];
  logic [CW:0]    inflight;
  logic           alloc, resp_fill, bypass_hit, dec_valid, deq;
  always_comb begin
    inflight = {1'b0, occ_q} + {1'b0, discard_cnt_q};
    bus.imem_req_valid = ~rst & bus.pc_valid & ~bus.flush & (inflight < (CW+1)'(DEPTH));
    alloc = bus.imem_req_valid & bus.imem_req_ready;
    bus.fetch_stall = ~rst & bus.pc_valid & ~alloc;
    bus.imem_req_addr = rst ? '0 : bus.pc_in;
    resp_fill = bus.imem_resp_valid & (discard_cnt_q == '0) & (pend_q != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_hit = resp_fill & (fill_q == head_q);
`else
    bypass_hit = 1'b0;
`endif
    dec_valid = ~rst & ~bus.flush & (filled_q[head_q] | bypass_hit);
    deq = dec_valid & bus.dec_ready;
    bus.dec_valid = dec_valid;
    bus.dec_pc = rst ? '0 : pc_q[head_q];
    bus.dec_instr = rst ? '0 : (bypass_hit ? bus.imem_resp_data : instr_q[head_q]);
    bus.occupancy = occ_q;
    // Requests still owed a response; on flush these become discards, less any arriving now.
    owed = pend_q + discard_cnt_q;
    occ_d = bus.flush ? '0 : occ_q + CW'(alloc) - CW'(deq);
    pend_d = bus.flush ? '0 : pend_q + CW'(alloc) - CW'(resp_fill);
    discard_cnt_d = bus.flush ? owed - CW'(bus.imem_resp_valid & (owed != '0))
                              : discard_cnt_q - CW'(bus.imem_resp_valid & (discard_cnt_q != '0));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      filled_q <= '0;
      occ_q <= '0;
      pend_q <= '0;
      discard_cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      pend_q <= pend_d;
      discard_cnt_q <= discard_cnt_d;
      if (bus.flush) begin
        head_q <= '0;
        fill_q <= '0;
        tail_q <= '0;
        filled_q <= '0;
      end else begin
        if (alloc) begin
          filled_q[tail_q] <= 1'b0;
          tail_q <= tail_q + 1'b1;
        end
        if (resp_fill) fill_q <= fill_q + 1'b1;
        if (resp_fill & ~(bypass_hit & deq)) filled_q[fill_q] <= 1'b1;
        if (deq) begin
          filled_q[head_q] <= 1'b0;
          head_q <= head_q + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) pc_q[tail_q] <= bus.pc_in;
    if (resp_fill & ~bus.flush) instr_q[fill_q] <= bus.imem_resp_data;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed tests of fetch_queue against an in-order latency-1 memory model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_queue_if #(.DEPTH(DEPTH)) bus();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errs = 0;
  int checks = 0;
  logic mem_en = 1'b0;
  logic mem_has;
  logic [31:0] mem_head;
  logic [31:0] mq [$];
  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mem_has <= 1'b0;
      mem_head <= '0;
    end else begin
      if (bus.imem_resp_valid) void'(mq.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) mq.push_back(bus.imem_req_addr);
      mem_has <= mq.size() > 0;
      mem_head <= (mq.size() > 0) ? mq[0] : '0;
    end
  end
  assign bus.imem_resp_valid = mem_en & mem_has;
  assign bus.imem_resp_data = ins(mem_head);
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    @(posedge clk);
    #1;
    bus.pc_valid = 1'b1;
    bus.pc_in = 32'h1234;
    bus.imem_req_ready = 1'b1;
    #1;
    checks++;
    if ({bus.imem_req_valid, bus.fetch_stall, bus.dec_valid} !== 3'b000 || bus.occupancy !== '0 || bus.imem_req_addr !== '0 || bus.dec_pc !== '0) begin
      errs++;
      $display("FAIL reset_outputs got req=%b stall=%b dv=%b occ=%0d addr=%h dpc=%h want all 0", bus.imem_req_valid, bus.fetch_stall, bus.dec_valid, bus.occupancy, bus.imem_req_addr, bus.dec_pc);
    end
    step();
    rst = 1'b0;
    bus.pc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== '0 || dut.discard_cnt_q !== '0 || bus.dec_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_state got occ=%0d disc=%0d dv=%b want 0 0 0", bus.occupancy, dut.discard_cnt_q, bus.dec_valid);
    end
    step();
  endtask
  task automatic test_stream;
    int nxt = 0;
    bus.dec_ready = 1'b1;
    mem_en = 1'b1;
    bus.imem_req_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.pc_valid = c < 8;
      bus.pc_in = 32'(c * 4);
      @(negedge clk);
      checks++;
      if (bus.fetch_stall !== 1'b0) begin
        errs++;
        $display("FAIL stream_stall c=%0d got=%b want=0", c, bus.fetch_stall);
      end
      checks++;
      if (bus.dec_valid !== (c >= LAT && c < LAT + 8)) begin
        errs++;
        $display("FAIL stream_dec_valid c=%0d got=%b want=%b", c, bus.dec_valid, (c >= LAT && c < LAT + 8));
      end
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== 32'(nxt * 4) || bus.dec_instr !== ins(32'(nxt * 4))) begin
          errs++;
          $display("FAIL stream_data c=%0d got pc=%h instr=%h want pc=%h instr=%h", c, bus.dec_pc, bus.dec_instr, 32'(nxt * 4), ins(32'(nxt * 4)));
        end
        nxt++;
      end
      step();
    end
    checks++;
    if (nxt != 8 || bus.occupancy !== '0) begin
      errs++;
      $display("FAIL stream_count got n=%0d occ=%0d want n=8 occ=0", nxt, bus.occupancy);
    end
  endtask
  task automatic test_full;
    int k = 0;
    int got = 0;
    logic exp_stall;
    mem_en = 1'b1;
    bus.imem_req_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.pc_valid = k < 5;
      bus.pc_in = 32'h40 + 32'(k * 4);
      bus.dec_ready = c >= 6;
      exp_stall = bus.pc_valid && c >= 4 && c <= 6;
      @(negedge clk);
      checks++;
      if (bus.fetch_stall !== exp_stall) begin
        errs++;
        $display("FAIL full_stall c=%0d got=%b want=%b", c, bus.fetch_stall, exp_stall);
      end
      if (c == 4) begin
        checks++;
        if (bus.occupancy !== 3'd4 || bus.imem_req_valid !== 1'b0) begin
          errs++;
          $display("FAIL full_occ got occ=%0d req=%b want occ=4 req=0", bus.occupancy, bus.imem_req_valid);
        end
      end
      if (bus.dec_valid && bus.dec_ready) begin
        checks++;
        if (bus.dec_pc !== 32'h40 + 32'(got * 4) || bus.dec_instr !== ins(32'h40 + 32'(got * 4))) begin
          errs++;
          $display("FAIL full_data c=%0d got pc=%h want pc=%h", c, bus.dec_pc, 32'h40 + 32'(got * 4));
        end
        got++;
      end
      if (bus.pc_valid && !exp_stall) k++;
      step();
    end
    checks++;
    if (got != 5 || bus.occupancy !== '0) begin
      errs++;
      $display("FAIL full_count got n=%0d occ=%0d want n=5 occ=0", got, bus.occupancy);
    end
  endtask
  task automatic test_flush;
    int got = 0;
    bus.dec_ready = 1'b0;
    mem_en = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_in = 32'h200;
    step();
    bus.pc_in = 32'h204;
    step();
    mem_en = 1'b0;
    bus.pc_in = 32'h208;
    step();
    bus.pc_in = 32'h20C;
    step();
    bus.pc_in = 32'h210;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.fetch_stall !== 1'b1 || bus.occupancy !== 3'd4) begin
      errs++;
      $display("FAIL flush_cycle got dv=%b req=%b stall=%b occ=%0d want 0 0 1 4", bus.dec_valid, bus.imem_req_valid, bus.fetch_stall, bus.occupancy);
    end
    step();
    bus.flush = 1'b0;
    bus.pc_in = 32'h100;
    mem_en = 1'b1;
    bus.dec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== '0 || dut.discard_cnt_q !== 3'd3 || bus.dec_valid !== 1'b0 || bus.fetch_stall !== 1'b0) begin
      errs++;
      $display("FAIL flush_after got occ=%0d disc=%0d dv=%b stall=%b want 0 3 0 0", bus.occupancy, dut.discard_cnt_q, bus.dec_valid, bus.fetch_stall);
    end
    step();
    bus.pc_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== 32'h100 || bus.dec_instr !== ins(32'h100)) begin
          errs++;
          $display("FAIL flush_new got pc=%h instr=%h want pc=%h instr=%h", bus.dec_pc, bus.dec_instr, 32'h100, ins(32'h100));
        end
        got++;
      end
      step();
    end
    checks++;
    if (got != 1 || dut.discard_cnt_q !== '0 || bus.occupancy !== '0) begin
      errs++;
      $display("FAIL flush_drain got n=%0d disc=%0d occ=%0d want 1 0 0", got, dut.discard_cnt_q, bus.occupancy);
    end
  endtask
  task automatic test_flush_resp;
    mem_en = 1'b0;
    bus.dec_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_in = 32'h300;
    step();
    bus.pc_in = 32'h304;
    step();
    bus.pc_valid = 1'b0;
    mem_en = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.dec_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_resp_dv got=%b want=0", bus.dec_valid);
    end
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.discard_cnt_q !== 3'd1 || bus.occupancy !== '0) begin
      errs++;
      $display("FAIL flush_resp_disc got disc=%0d occ=%0d want 1 0", dut.discard_cnt_q, bus.occupancy);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.dec_valid !== 1'b0) begin
        errs++;
        $display("FAIL flush_resp_leak c=%0d got dv=%b pc=%h want dv=0", c, bus.dec_valid, bus.dec_pc);
      end
      step();
    end
    checks++;
    if (dut.discard_cnt_q !== '0) begin
      errs++;
      $display("FAIL flush_resp_end got disc=%0d want 0", dut.discard_cnt_q);
    end
  endtask
  task automatic test_backpressure;
    int k = 0;
    int got = 0;
    bus.dec_ready = 1'b1;
    mem_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.pc_valid = c < 8;
      bus.imem_req_ready = (c % 2) == 0;
      bus.pc_in = 32'h400 + 32'(k * 4);
      @(negedge clk);
      checks++;
      if (bus.fetch_stall !== (bus.pc_valid && !bus.imem_req_ready)) begin
        errs++;
        $display("FAIL bp_stall c=%0d got=%b want=%b", c, bus.fetch_stall, (bus.pc_valid && !bus.imem_req_ready));
      end
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== 32'h400 + 32'(got * 4) || bus.dec_instr !== ins(32'h400 + 32'(got * 4))) begin
          errs++;
          $display("FAIL bp_data c=%0d got pc=%h want pc=%h", c, bus.dec_pc, 32'h400 + 32'(got * 4));
        end
        got++;
      end
      if (bus.pc_valid && bus.imem_req_ready) k++;
      step();
    end
    bus.imem_req_ready = 1'b1;
    checks++;
    if (got != 4 || bus.occupancy !== '0) begin
      errs++;
      $display("FAIL bp_count got n=%0d occ=%0d want n=4 occ=0", got, bus.occupancy);
    end
  endtask
  task automatic test_async_reset;
    int got = 0;
    bus.dec_ready = 1'b0;
    mem_en = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_in = 32'h500;
    step();
    bus.pc_in = 32'h504;
    step();
    bus.pc_in = 32'h508;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.dec_valid, bus.fetch_stall, bus.imem_req_valid} !== 3'b000 || bus.occupancy !== '0 || bus.imem_req_addr !== '0 || bus.dec_pc !== '0 || bus.dec_instr !== '0) begin
      errs++;
      $display("FAIL async_reset got dv=%b stall=%b req=%b occ=%0d addr=%h pc=%h instr=%h want all 0", bus.dec_valid, bus.fetch_stall, bus.imem_req_valid, bus.occupancy, bus.imem_req_addr, bus.dec_pc, bus.dec_instr);
    end
    step();
    rst = 1'b0;
    bus.pc_in = 32'h0;
    bus.dec_ready = 1'b1;
    step();
    bus.pc_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== 32'h0 || bus.dec_instr !== ins(32'h0)) begin
          errs++;
          $display("FAIL reset_fetch got pc=%h instr=%h want pc=%h instr=%h", bus.dec_pc, bus.dec_instr, 32'h0, ins(32'h0));
        end
        got++;
      end
      step();
    end
    checks++;
    if (got != 1 || bus.occupancy !== '0) begin
      errs++;
      $display("FAIL reset_fetch_count got n=%0d occ=%0d want 1 0", got, bus.occupancy);
    end
  endtask
  initial begin
    bus.pc_valid = 1'b0;
    bus.pc_in = '0;
    bus.flush = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.dec_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_flush_resp();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
